// File: rtl/div_unit_if.sv
// Request/result bundle between the control path and div_unit.
// The master issues divisions; the slave (the divider) returns results.
interface div_unit_if #(
  parameter int Width = 32
);
  logic             start;
  logic             op_signed;
  logic [Width-1:0] dividend;
  logic [Width-1:0] divisor;
  logic             busy;
  logic             done;
  logic [Width-1:0] quotient;
  logic [Width-1:0] remainder;

  modport master (
    output start, op_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, op_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to honour op_signed (RISC-V DIV/REM semantics).
module div_unit #(
  parameter int Width = 32
) (
  input logic        clk,
  input logic        rst_n,
  div_unit_if.slave  dp
);

  localparam int CntW = $clog2(Width) + 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(Width - 1);
  localparam logic [CntW-1:0]  CntOne  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [Width-1:0] WOne    = {{(Width-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [Width-1:0] quotient_q;
  logic [Width-1:0] remainder_q;
  logic [Width:0]   prem_q;
  logic [Width-1:0] qsh_q;
  logic [Width-1:0] dvd_q;
  logic [Width-1:0] dsr_q;
  logic [CntW-1:0]  cnt_q;

  logic [Width-1:0] opa_s;
  logic [Width-1:0] opb_s;
  logic [Width+1:0] trial_s;
  logic [Width:0]   prem_nx_s;
  logic [Width-1:0] qsh_nx_s;
  logic [Width-1:0] quo_fin_s;
  logic [Width-1:0] rem_fin_s;

  function automatic logic [Width-1:0] negate(input logic [Width-1:0] v);
    return ~v + WOne;
  endfunction

`ifdef DIV_SIGNED_EN
  logic sgn_a_s;
  logic sgn_b_s;
  logic negq_q;
  logic negr_q;
`else
  logic unused_op_signed_s;
  assign unused_op_signed_s = dp.op_signed;
`endif

  // Operand conditioning: magnitudes are divided, signs are restored at the end.
  always_comb begin
    opa_s = dp.dividend;
    opb_s = dp.divisor;
`ifdef DIV_SIGNED_EN
    sgn_a_s = dp.op_signed & dp.dividend[Width-1];
    sgn_b_s = dp.op_signed & dp.divisor[Width-1];
    opa_s   = sgn_a_s ? negate(dp.dividend) : dp.dividend;
    opb_s   = sgn_b_s ? negate(dp.divisor)  : dp.divisor;
`endif
  end

  // One restoring step plus the sign-corrected final values.
  always_comb begin
    trial_s = {prem_q, dvd_q[Width-1]} - {2'b00, dsr_q};
    if (!trial_s[Width+1]) begin
      prem_nx_s = trial_s[Width:0];
      qsh_nx_s  = {qsh_q[Width-2:0], 1'b1};
    end else begin
      prem_nx_s = {prem_q[Width-1:0], dvd_q[Width-1]};
      qsh_nx_s  = {qsh_q[Width-2:0], 1'b0};
    end
    quo_fin_s = qsh_nx_s;
    rem_fin_s = prem_nx_s[Width-1:0];
`ifdef DIV_SIGNED_EN
    quo_fin_s = negq_q ? negate(qsh_nx_s) : qsh_nx_s;
    rem_fin_s = negr_q ? negate(prem_nx_s[Width-1:0]) : prem_nx_s[Width-1:0];
`endif
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      prem_q      <= '0;
      qsh_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
`ifdef DIV_SIGNED_EN
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (dp.start) begin
            dvd_q  <= opa_s;
            dsr_q  <= opb_s;
            prem_q <= '0;
            qsh_q  <= '0;
            cnt_q  <= '0;
`ifdef DIV_SIGNED_EN
            negq_q <= sgn_a_s ^ sgn_b_s;
            negr_q <= sgn_a_s;
`endif
            // Divide by zero bypasses CALC and reports immediately.
            if (dp.divisor == '0) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dp.dividend;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          prem_q <= prem_nx_s;
          qsh_q  <= qsh_nx_s;
          dvd_q  <= {dvd_q[Width-2:0], 1'b0};
          cnt_q  <= cnt_q + CntOne;
          if (cnt_q == LastCnt) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= quo_fin_s;
            remainder_q <= rem_fin_s;
          end else begin
            state_q <= CALC;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dp.busy      = busy_q;
  assign dp.done      = done_q;
  assign dp.quotient  = quotient_q;
  assign dp.remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level behavioural model plus directed literal checks.
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  div_unit_if #(.Width(W)) dif ();
  div_unit #(.Width(W)) dut (.clk(clk), .rst_n(rst_n), .dp(dif));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the division rules.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
`ifdef DIV_SIGNED_EN
      if (sg) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = a;
          r = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
      end
`endif
    end
  endfunction

  // Model state: cycles left before done, plus the pending result.
  int         m_left;
  logic       m_busy, m_done;
  logic [W-1:0] m_q, m_r, p_q, p_r;

  initial begin
    m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_q = '0; m_r = '0; p_q = '0; p_r = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_q = '0; m_r = '0;
      end else if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
        m_busy = (m_left > 0);
        if (m_left == 0) begin
          m_q = p_q;
          m_r = p_r;
        end
      end else if (dif.start) begin
        ref_div(dif.dividend, dif.divisor, dif.op_signed, p_q, p_r);
        if (dif.divisor == 32'd0) begin
          m_done = 1'b1; m_busy = 1'b0; m_q = p_q; m_r = p_r;
        end else begin
          m_done = 1'b0; m_busy = 1'b1; m_left = W;
        end
      end else begin
        m_done = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(dif.busy), 64'(m_busy));
      chk("done", 64'(dif.done), 64'(m_done));
      chk("quotient", 64'(dif.quotient), 64'(m_q));
      chk("remainder", 64'(dif.remainder), 64'(m_r));
    end
  end

  task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dif.start = 1'b1; dif.dividend = a; dif.divisor = b; dif.op_signed = s;
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    kick(a, b, s);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (dif.done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 64'(dif.done), 64'd1);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'($urandom_range(1, 15));
      2: return 32'($urandom);
      default: begin
        case ($urandom_range(0, 2))
          0: return 32'h8000_0000;
          1: return 32'hFFFF_FFFF;
          default: return 32'd1;
        endcase
      end
    endcase
  endfunction

  int lat;
  logic [W-1:0] mq, mr;

  initial begin
    rst_n = 1'b0;
    dif.start = 1'b0; dif.op_signed = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 64'(dif.busy), 64'd0);
    chk("rst_done", 64'(dif.done), 64'd0);
    chk("rst_quot", 64'(dif.quotient), 64'd0);
    chk("rst_rem", 64'(dif.remainder), 64'd0);
    rst_n = 1'b1;

    // Pin the model arithmetic itself.
    ref_div(32'd100, 32'd7, 1'b0, mq, mr);
    chk("model_100_7_q", 64'(mq), 64'd14);
    chk("model_100_7_r", 64'(mr), 64'd2);

    pulse_start(32'd100, 32'd7, 1'b0);
    chk("calc_busy", 64'(dif.busy), 64'd1);
    wait_done(lat);
    chk("lat_100_7", 64'(lat), 64'd33);
    chk("q_100_7", 64'(dif.quotient), 64'd14);
    chk("r_100_7", 64'(dif.remainder), 64'd2);

    pulse_start(32'd5, 32'd0, 1'b0);
    wait_done(lat);
    chk("lat_div0", 64'(lat), 64'd1);
    chk("q_div0", 64'(dif.quotient), 64'hFFFF_FFFF);
    chk("r_div0", 64'(dif.remainder), 64'd5);
    repeat (3) @(negedge clk);

    // Start while busy is ignored.
    pulse_start(32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    kick(32'd9, 32'd3, 1'b0);
    wait_done(lat);
    chk("busy_start_lat", 64'(lat), 64'd24);
    chk("busy_start_q", 64'(dif.quotient), 64'd14);
    chk("busy_start_r", 64'(dif.remainder), 64'd2);
    @(negedge clk);
    chk("single_done", 64'(dif.done), 64'd0);
    repeat (40) @(negedge clk);

    // Reset mid-operation.
    pulse_start(32'd100, 32'd7, 1'b0);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(dif.busy), 64'd0);
    chk("abort_quot", 64'(dif.quotient), 64'd0);
    chk("abort_rem", 64'(dif.remainder), 64'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    pulse_start(32'd9, 32'd3, 1'b0);
    wait_done(lat);
    chk("lat_9_3", 64'(lat), 64'd33);
    chk("q_9_3", 64'(dif.quotient), 64'd3);
    chk("r_9_3", 64'(dif.remainder), 64'd0);

    // Back-to-back: restart in the DONE cycle.
    pulse_start(32'd100, 32'd7, 1'b0);
    wait_done(lat);
    kick(32'hFFFF_FFFF, 32'd16, 1'b0);
    chk("b2b_hold_q", 64'(dif.quotient), 64'd14);
    wait_done(lat);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_q", 64'(dif.quotient), 64'h0FFF_FFFF);
    chk("b2b_r", 64'(dif.remainder), 64'd15);

`ifdef DIV_SIGNED_EN
    pulse_start(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(lat);
    chk("s_q_m7_2", 64'(dif.quotient), 64'hFFFF_FFFD);
    chk("s_r_m7_2", 64'(dif.remainder), 64'hFFFF_FFFF);
    pulse_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat);
    chk("s_ovf_q", 64'(dif.quotient), 64'h8000_0000);
    chk("s_ovf_r", 64'(dif.remainder), 64'd0);
`endif

    // Random traffic, including starts while busy and sporadic resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n         = ($urandom_range(0, 299) != 0);
      dif.start     = ($urandom_range(0, 9) == 0);
      dif.op_signed = 1'($urandom_range(0, 1));
      dif.dividend  = rnd_op();
      dif.divisor   = rnd_op();
    end
    @(negedge clk);
    rst_n = 1'b1;
    dif.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider for the single-cycle RISC datapath: the inverse companion to the combinational adder. It produces one quotient bit per clock by restoring shift-subtract. It is started by a one-cycle request from the control path and returns quotient and remainder with a one-cycle done pulse. The datapath stalls on `busy` while a division is in flight.

## Interface
- `Width`, default 32: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request strobe; accepted only when state is IDLE or DONE.
- `op_signed`  in  1  1 = signed division, 0 = unsigned; sampled with `start`.
- `dividend`  in  Width  numerator; sampled with `start`.
- `divisor`  in  Width  denominator; sampled with `start`.
- `busy`  out  1  high while a division is in flight.
- `done`  out  1  one-cycle pulse when results are valid.
- `quotient`  out  Width  registered result.
- `remainder`  out  Width  registered result.

## Operation
- States are IDLE, CALC and DONE.
  - Reset state is IDLE.
  - Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, iteration counter=0.
- IDLE or DONE, with `start`=1: operands are latched and the state moves to CALC.
  - If `divisor`==0 the state goes directly to DONE.
- IDLE or DONE, with `start`=0: DONE returns to IDLE; IDLE stays in IDLE.
- CALC:
  - Working registers are partial remainder (Width+1 bits), shifting quotient (Width bits) and counter (log2(Width)+1 bits).
  - Each cycle the partial remainder is shifted left, taking the next dividend MSB, and trial-subtracted by the divisor.
  - If the trial result is non-negative, it is kept and a 1 is shifted into the quotient; otherwise a 0 is shifted in.
  - After exactly Width iterations the state moves to DONE.
- DONE: `quotient` and `remainder` load the final values and `done`=1 for this one cycle.
  - The outputs then hold until the next accepted `start`.
- Divide by zero: `quotient` = all ones, `remainder` = `dividend`. This applies to both signed and unsigned operation.
- A `start` arriving in CALC is ignored. It is neither queued nor allowed to alter the latched operands.
- Unsigned arithmetic is modulo 2^Width; the remainder is always less than the divisor.

## Timing
- Cycle 0: `start` is sampled high.
- Cycles 1..Width: CALC, with `busy`=1.
- Cycle Width+1: DONE, with `done`=1, `busy`=0 and valid outputs.
- Total latency from `start` to `done` is Width+1 cycles; it is 33 for Width=32.
- Divide by zero: `done` is asserted in cycle 1, so latency is 1 and `busy` stays 0.
- Back-to-back operation: `start` may be asserted in the DONE cycle.
  - The new operation enters CALC in the next cycle.
  - `quotient`/`remainder` keep the old result until the new DONE.
- Reset takes priority over all other inputs.
  - `rst_n`=0 during CALC aborts the operation: the next cycle is IDLE with all outputs zero and no `done` pulse.
- `done` is never high for two consecutive cycles unless a division by zero is restarted every cycle.

## Configuration
- Macro: `DIV_SIGNED_EN`.
- Defined:
  - `op_signed`=1 divides the absolute values in CALC and applies the sign correction in the DONE load. Latency is unchanged.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend, giving RISC-V DIV/REM semantics.
  - Overflow case: -2^(Width-1) / -1 gives `quotient` = -2^(Width-1) and `remainder` = 0.
- Not defined: the `op_signed` port still exists but is ignored. All operations are unsigned and no sign-correction logic is built.

## Test plan
- Width=32, unsigned: `dividend`=100, `divisor`=7, `start` at cycle 0 -> `done` at cycle 33 with `quotient`=14, `remainder`=2; `busy` high in cycles 1–32.
- Divide by zero: `dividend`=5, `divisor`=0 -> `done` at cycle 1 with `quotient`=0xFFFFFFFF, `remainder`=5; `busy` never high.
- `DIV_SIGNED_EN` defined, `op_signed`=1:
  - -7 / 2 -> `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0.
- Start while busy: 100/7 started, then `start` with 9/3 at cycle 10 -> at cycle 33 the result is still `quotient`=14, `remainder`=2, and only one `done` pulse occurs.
- Reset mid-operation: `rst_n`=0 at cycle 15 of 100/7 -> cycle 16 has all outputs 0 and no `done` thereafter. A fresh start of 9/3 then gives `quotient`=3, `remainder`=0 after 33 cycles.
- Back-to-back: 100/7, then `start` with 0xFFFFFFFF/16 in the DONE cycle (33) -> second `done` at cycle 66 with `quotient`=0x0FFFFFFF, `remainder`=15.
